// File: rtl/sar_adc_ctrl.sv
// Successive-approximation controller: samples, then resolves N comparator
// decisions MSB first into an N-bit result with a one-cycle done pulse.
module sar_adc_ctrl #(
  parameter int N             = 8,
  parameter int SAMPLE_CYCLES = 2,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         start_i,
  input  logic         cmp_i,
  output logic         sample_o,
  output logic [N-1:0] dac_code_o,
  output logic         busy_o,
  output logic         done_o,
  output logic [N-1:0] data_o,
  output logic [2:0]   state_o
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SAMPLE = 3'd1,
    S_SETTLE = 3'd2,
    S_DECIDE = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  localparam int KW = $clog2(N);
  localparam logic [3:0]    SAMPLE_LOAD = 4'(SAMPLE_CYCLES - 1);
  localparam logic [3:0]    SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);
  localparam logic [N-1:0]  MSB_CODE    = {1'b1, {(N-1){1'b0}}};
  localparam logic [N-1:0]  ONE_CODE    = {{(N-1){1'b0}}, 1'b1};

  state_t        state_q, state_d;
  logic [3:0]    cnt_q;
  logic [KW-1:0] bit_q;
  logic [N-1:0]  code_q;
  logic [N-1:0]  data_q;
  logic [N-1:0]  bit_mask;
  logic [N-1:0]  decided_code;
  logic [N-1:0]  next_trial;

  // Resolve the current bit from the comparator, then OR in the next trial bit.
  // When bit 0 is being decided the shifted mask is zero, so no trial is added.
  always_comb begin
    bit_mask     = ONE_CODE << bit_q;
    decided_code = (code_q & ~bit_mask) | (cmp_i ? bit_mask : '0);
    next_trial   = decided_code | (bit_mask >> 1);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start_i) state_d = S_SAMPLE;
      S_SAMPLE: if (cnt_q == 4'd0) state_d = S_SETTLE;
      S_SETTLE: if (cnt_q == 4'd0) state_d = S_DECIDE;
      S_DECIDE: state_d = (bit_q == '0) ? S_DONE : S_SETTLE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    sample_o   = (state_q == S_SAMPLE);
    busy_o     = (state_q != S_IDLE);
    done_o     = (state_q == S_DONE);
    dac_code_o = code_q;
    data_o     = data_q;
    state_o    = state_q;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q  <= 4'd0;
      bit_q  <= '0;
      code_q <= '0;
      data_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            cnt_q  <= SAMPLE_LOAD;
            code_q <= '0;
            bit_q  <= KW'(N - 1);
          end
        end
        S_SAMPLE: begin
          if (cnt_q == 4'd0) begin
            code_q <= MSB_CODE;
            cnt_q  <= SETTLE_LOAD;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        S_SETTLE: begin
          if (cnt_q != 4'd0) cnt_q <= cnt_q - 4'd1;
        end
        S_DECIDE: begin
          code_q <= next_trial;
          if (bit_q != '0) begin
            bit_q <= bit_q - KW'(1);
            cnt_q <= SETTLE_LOAD;
          end else begin
            data_q <= decided_code;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sar_adc_ctrl.sv
// Directed bench for sar_adc_ctrl at default parameters with a behavioural
// comparator: cmp = vin > dac_code, vin held in tenths of an LSB.
module tb_sar_adc_ctrl;

  logic       clk_i;
  logic       rst_i;
  logic       start_i;
  logic       cmp_i;
  logic       sample_o;
  logic [7:0] dac_code_o;
  logic       busy_o;
  logic       done_o;
  logic [7:0] data_o;
  logic [2:0] state_o;

  int checks   = 0;
  int failures = 0;
  int vin10    = 0;

  logic [7:0] walk_exp [0:7];

  sar_adc_ctrl #(.N(8), .SAMPLE_CYCLES(2), .SETTLE_CYCLES(1)) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .start_i    (start_i),
    .cmp_i      (cmp_i),
    .sample_o   (sample_o),
    .dac_code_o (dac_code_o),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .data_o     (data_o),
    .state_o    (state_o)
  );

  assign cmp_i = (vin10 > int'(dac_code_o) * 10);

  // clock / reset
  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  initial begin
    #200us;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One full conversion from an idle block; start pulsed for one edge (E0).
  task automatic run_conv(input int v10, input logic [7:0] exp_data, input bit chk_walk);
    int         busy_cnt;
    int         done_cnt;
    logic [7:0] held;
    held    = 8'h00;
    vin10   = v10;
    @(negedge clk_i) start_i = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    check("sample_rise", 16'(sample_o), 16'd1);
    check("busy_rise", 16'(busy_o), 16'd1);
    busy_cnt = 1;
    done_cnt = 0;
    for (int e = 1; e <= 19; e++) begin
      @(posedge clk_i); #1;
      if (busy_o) busy_cnt++;
      if (done_o) done_cnt++;
      if (e == 1) check("sample_hold", 16'(sample_o), 16'd1);
      if (e == 2) check("sample_fall", 16'(sample_o), 16'd0);
      if (e >= 2 && e <= 16 && (e % 2) == 0) begin
        held = dac_code_o;
        if (chk_walk) check("walk", 16'(dac_code_o), 16'(walk_exp[(e - 2) / 2]));
      end
      if (e >= 3 && e <= 17 && (e % 2) == 1) begin
        check("settle_stable", 16'(dac_code_o), 16'(held));
        check("decide_state", 16'(state_o), 16'd3);
      end
      if (e == 18) begin
        check("done_pulse", 16'(done_o), 16'd1);
        check("data_result", 16'(data_o), 16'(exp_data));
        check("dac_final", 16'(dac_code_o), 16'(exp_data));
      end
      if (e == 19) begin
        check("done_clear", 16'(done_o), 16'd0);
        check("busy_fall", 16'(busy_o), 16'd0);
        check("data_hold", 16'(data_o), 16'(exp_data));
        check("dac_hold", 16'(dac_code_o), 16'(exp_data));
      end
    end
    check("busy_len", 16'(busy_cnt), 16'd19);
    check("done_count", 16'(done_cnt), 16'd1);
  endtask

  initial begin
    int dn;
    int w;
    int v;
    rst_i   = 1'b0;
    start_i = 1'b0;

    // asynchronous reset between edges
    #3 rst_i = 1'b1;
    #1;
    check("rst_sample", 16'(sample_o), 16'd0);
    check("rst_busy", 16'(busy_o), 16'd0);
    check("rst_done", 16'(done_o), 16'd0);
    check("rst_dac", 16'(dac_code_o), 16'd0);
    check("rst_data", 16'(data_o), 16'd0);
    check("rst_state", 16'(state_o), 16'd0);
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;

    // vin = 90.5
    walk_exp[0] = 8'h80; walk_exp[1] = 8'h40; walk_exp[2] = 8'h60; walk_exp[3] = 8'h50;
    walk_exp[4] = 8'h58; walk_exp[5] = 8'h5C; walk_exp[6] = 8'h5A; walk_exp[7] = 8'h5B;
    run_conv(905, 8'h5A, 1'b1);

    // boundaries
    run_conv(3, 8'h00, 1'b0);
    run_conv(2557, 8'hFF, 1'b0);

    // start held high: back-to-back conversions every 20 cycles
    vin10 = 2005;
    dn = 0;
    @(negedge clk_i) start_i = 1'b1;
    for (int c = 0; c <= 61; c++) begin
      @(posedge clk_i); #1;
      if (done_o) begin
        check("b2b_data", 16'(data_o), 16'h00C8);
        check("b2b_spacing", 16'(c), 16'(18 + 20 * dn));
        dn++;
      end
    end
    check("b2b_count", 16'(dn), 16'd3);
    @(negedge clk_i) start_i = 1'b0;
    w = 0;
    while (busy_o && w < 40) begin
      @(posedge clk_i); #1;
      w++;
    end
    check("b2b_idle", 16'(busy_o), 16'd0);

    // reset during the fifth DECIDE cycle of a vin = 150.5 conversion
    vin10 = 1505;
    @(negedge clk_i) start_i = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    repeat (11) @(posedge clk_i);
    #1;
    check("abort_in_decide", 16'(state_o), 16'd3);
    check("abort_prev_data", 16'(data_o), 16'h00C8);
    #2 rst_i = 1'b1;
    #1;
    check("abort_data", 16'(data_o), 16'd0);
    check("abort_dac", 16'(dac_code_o), 16'd0);
    check("abort_busy", 16'(busy_o), 16'd0);
    check("abort_state", 16'(state_o), 16'd0);
    @(negedge clk_i) rst_i = 1'b0;
    dn = 0;
    for (int c = 0; c < 25; c++) begin
      @(posedge clk_i); #1;
      if (done_o) dn++;
    end
    check("abort_no_done", 16'(dn), 16'd0);
    check("abort_data_kept", 16'(data_o), 16'd0);
    run_conv(1505, 8'h96, 1'b0);

    // randomized vin = k + 0.5
    for (int i = 0; i < 10; i++) begin
      v = $urandom_range(0, 255);
      run_conv(v * 10 + 5, 8'(v), 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
